// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the host-memory arbiter and its pickers.
// State encoding is fixed so debug views and later schedulers agree on it.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    // Index width for a one-of-n selector; never returns less than 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first set request at or above ptr, wrapping.
// Zero latency; no backpressure, found=0 when no request is set.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found                      = 1'b1;
                gnt[(int'(ptr) + k) % N]   = 1'b1;
                idx                        = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one host-memory wrapper, one access in flight.
// Accept at T, mem_req at T+1, response at T+3; requests wait (req_ready low) while busy. Timeout: MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int IDX_W         = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_valid,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id
);

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]     grant_nxt;
    logic [NUM_REQ-1:0]   req_ready_nxt, rsp_valid_nxt;
    logic [DATA_W-1:0]    rsp_rdata_nxt, mem_wdata_nxt;
    logic [ADDR_W-1:0]    mem_addr_nxt;
    logic                 rsp_err_nxt, mem_req_nxt, mem_we_nxt, busy_nxt;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    // The ack is due one cycle into WAIT, so the budget runs from that cycle.
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES + 1);
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wait_cnt <= '0;
        else if (state != WAIT)  wait_cnt <= '0;
        else                     wait_cnt <= wait_cnt + 16'd1;
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_nxt     = grant_id;
        req_ready_nxt = '0;
        rsp_valid_nxt = '0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = 1'b0;
        mem_req_nxt   = 1'b0;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    req_ready_nxt = pick_gnt;
                    mem_we_nxt    = req_we[pick_idx];
                    mem_addr_nxt  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    mem_wdata_nxt = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    grant_nxt     = pick_idx;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_nxt = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    rsp_valid_nxt = NUM_REQ'(1) << grant_id;
                    rsp_rdata_nxt = mem_we ? '0 : mem_rdata;
                    state_nxt     = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt == TO_LIMIT) begin
                    rsp_valid_nxt = NUM_REQ'(1) << grant_id;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    state_nxt     = RESP;
                end
`endif
            end
            RESP: begin
                rr_ptr_nxt = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_id  <= grant_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester queues drive stimulus, a monitor predicts grants and responses.
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req_valid = '0, req_we = '0, req_ready, rsp_valid;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [DW-1:0]     rsp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]     mem_addr;
    logic              rsp_err, mem_req, mem_we, mem_valid, busy;
    logic [IW-1:0]     grant_id;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy), .grant_id(grant_id)
    );

    typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; } txn_t;
    typedef struct { int id; logic [63:0] data; logic err; int due; } rsp_t;

    txn_t        rq[N][$];
    rsp_t        exp_q[$];
    int          grant_log[$];
    logic [63:0] ref_mem[logic [63:0]];
    logic [63:0] wmem[logic [63:0]];

    int tests = 0, fails = 0;
    int cyc = 0, last_acc = -100, m_ptr = 0, rsp_seen = 0;
    int m_due = -1;
    logic        m_we;
    logic [63:0] m_addr, m_wdata;
    logic        ack_r = 1'b0, spur = 1'b0, no_ack = 1'b0, pend = 1'b0, drop_en = 1'b0;
    logic [63:0] pend_rd = '0, rdata_r = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] dflt(input logic [63:0] a);
        return a ^ 64'h5A5A_0000_C3C3_0000;
    endfunction

    // Round-robin rule: first asserted requester at or after the pointer, modulo N.
    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Memory wrapper: ack and data one cycle after it samples mem_req.
    assign mem_valid = ack_r | spur;
    assign mem_rdata = rdata_r;
    always @(negedge clk) begin
        ack_r   = pend;
        rdata_r = pend_rd;
        pend    = 1'b0;
        if (mem_req && !no_ack && rst_n) begin
            pend = 1'b1;
            if (mem_we) begin
                wmem[mem_addr] = mem_wdata;
                pend_rd = {$urandom, $urandom};
            end else begin
                pend_rd = wmem.exists(mem_addr) ? wmem[mem_addr] : dflt(mem_addr);
            end
        end
    end

    // Requesters: hold the queue head until accepted, otherwise scramble the inputs.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0 && !(drop_en && $urandom_range(0, 7) == 0)) begin
                req_valid[i]               = 1'b1;
                req_we[i]                  = rq[i][0].we;
                req_addr[i*AW +: AW]       = rq[i][0].addr;
                req_wdata[i*DW +: DW]      = rq[i][0].wdata;
            end else begin
                req_valid[i]               = 1'b0;
                req_we[i]                  = 1'($urandom);
                req_addr[i*AW +: AW]       = {$urandom, $urandom};
                req_wdata[i*DW +: DW]      = {$urandom, $urandom};
            end
        end
    end

    // Monitor and reference model.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            chk("reset_ctrl", 64'({req_ready, rsp_valid, rsp_err, mem_req, mem_we, busy, grant_id}), 64'd0);
            chk("reset_data", rsp_rdata | mem_addr | mem_wdata, 64'd0);
            exp_q.delete();
            m_due = -1;
            m_ptr = 0;
            last_acc = -100;
        end else begin
            if (req_ready != '0) begin
                int g;
                txn_t t;
                rsp_t r;
                g = winner(req_valid, m_ptr);
                chk("accept_grant", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
                chk("accept_spacing", 64'(cyc - last_acc >= 4), 64'd1);
                if (g >= 0) begin
                    chk("grant_id", 64'(grant_id), 64'(g));
                    chk("busy_on_accept", 64'(busy), 64'd1);
                    t = rq[g][0];
                    m_we = t.we; m_addr = t.addr; m_wdata = t.wdata; m_due = cyc + 1;
                    r.id = g; r.err = 1'b0; r.due = cyc + 3;
                    if (t.we) begin
                        r.data = '0;
                        ref_mem[t.addr] = t.wdata;
                    end else begin
                        r.data = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    if (no_ack) begin
                        r.data = '0; r.err = 1'b1; r.due = cyc + 2 + TO + 1;
                    end
`endif
                    exp_q.push_back(r);
                    grant_log.push_back(g);
                    m_ptr = (g + 1) % N;
                    last_acc = cyc;
                end
            end
            if (m_due == cyc || mem_req) begin
                chk("mem_req_timing", 64'(mem_req), 64'(m_due == cyc));
                if (m_due == cyc) begin
                    chk("mem_addr", mem_addr, m_addr);
                    chk("mem_we", 64'(mem_we), 64'(m_we));
                    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
                end
            end
            if (m_due + 1 == cyc) chk("mem_addr_hold", mem_addr, m_addr);
            if (rsp_valid != '0) rsp_seen++;
            if (rsp_valid != '0 || (exp_q.size() > 0 && exp_q[0].due == cyc)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    rsp_t r;
                    r = exp_q.pop_front();
                    chk("rsp_onehot", 64'(rsp_valid), 64'd1 << r.id);
                    chk("rsp_cycle", 64'(cyc), 64'(r.due));
                    chk("rsp_rdata", rsp_rdata, r.data);
                    chk("rsp_err", 64'(rsp_err), 64'(r.err));
                end
            end
        end
    end

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
        return exp_q.size() > 0;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 64'd1);
        repeat (3) @(posedge clk);
    endtask

    task automatic push(input int i, input logic we, input logic [63:0] a, input logic [63:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        rq[i].push_back(t);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int snap, n;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single read from requester 1.
        wmem[64'h100] = 64'hDEAD_BEEF;
        ref_mem[64'h100] = 64'hDEAD_BEEF;
        @(posedge clk); #2;
        push(1, 1'b0, 64'h100, 64'h0);
        drain(100);

        // Write then read back on requester 0.
        @(posedge clk); #2;
        push(0, 1'b1, 64'h8, 64'h55);
        push(0, 1'b0, 64'h8, 64'h0);
        drain(100);

        // Fairness from a fresh pointer.
        do_reset(2);
        grant_log.delete();
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) push(i, 1'b0, 64'(16 * i + k), 64'h0);
        drain(300);
        chk("fair_count", 64'(grant_log.size()), 64'd12);
        for (int k = 0; k < 12 && k < grant_log.size(); k++)
            chk("fair_order", 64'(grant_log[k]), 64'(k % N));

        // Spurious ack while idle.
        snap = rsp_seen;
        @(negedge clk) spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        repeat (3) @(posedge clk);
        chk("spurious_ignored", 64'(rsp_seen), 64'(snap));

        // Randomised traffic with occasional request withdrawal.
        drop_en = 1'b1;
        for (int b = 0; b < 10; b++) begin
            @(posedge clk); #2;
            for (int k = 0; k < 4; k++)
                push($urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
                     64'($urandom_range(0, 7)) << 3, {$urandom, $urandom});
            repeat ($urandom_range(0, 10)) @(posedge clk);
        end
        drain(2000);
        drop_en = 1'b0;

        // Reset while waiting for the ack: in-flight response dropped, pointer back to 0.
        @(posedge clk); #2;
        push(1, 1'b0, 64'h20, 64'h0);
        drain(100);
        @(posedge clk); #2;
        push(2, 1'b0, 64'h28, 64'h0);
        n = 0;
        while (!req_ready[2] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_before_reset", 64'(req_ready[2]), 64'd1);
        @(posedge clk);
        snap = rsp_seen;
        do_reset(2);
        @(negedge clk) spur = 1'b1;
        @(negedge clk) spur = 1'b0;
        repeat (3) @(posedge clk);
        chk("no_rsp_after_reset", 64'(rsp_seen), 64'(snap));
        grant_log.delete();
        @(posedge clk); #2;
        push(3, 1'b0, 64'h30, 64'h0);
        push(0, 1'b0, 64'h38, 64'h0);
        drain(100);
        chk("post_reset_first_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Wrapper never acks: timeout response, then normal service resumes.
        no_ack = 1'b1;
        @(posedge clk); #2;
        push(3, 1'b0, 64'h40, 64'h0);
        drain(100);
        no_ack = 1'b0;
        @(posedge clk); #2;
        push(0, 1'b0, 64'h48, 64'h0);
        drain(100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
